// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter
//   Shares the single VGA adapter pixel-write port between NUM_REQ drawers.
//   A round-robin arbiter grants one requester at a time for a bounded burst.
//   A burst ends on the object's last pixel, after MAX_BURST pixels, or when
//   the requester drops req. One idle cycle always separates two bursts.
//
//   Optional feature macro: ARB_CLIP_EN. When it is defined, off-screen pixels
//   are still acked but never plotted, and the clip_cnt output counts them.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   enable                write enable from the control FSM; 0 pauses a burst
//   req/req_last          per-requester pixel valid / last pixel of the object
//   req_x/req_y/req_colour packed per-requester pixel; slice i = [i*W +: W]
//   grant                 registered one-hot grant
//   ack                   combinational accept = grant & req & enable
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel write, one cycle after ack
//   busy                  high while a grant is active
//   clip_cnt              (ARB_CLIP_EN only) saturating count of clipped pixels
module vga_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int MAX_BURST = 16,
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           ack,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy
`ifdef ARB_CLIP_EN
  ,
  output logic [15:0]                  clip_cnt
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                          state;
  logic [PTR_W-1:0]                ptr;
  logic [CNT_W-1:0]                burst_cnt;

  // Per-requester views of the packed pixel buses.
  logic [NUM_REQ-1:0][X_W-1:0]      px_x;
  logic [NUM_REQ-1:0][Y_W-1:0]      px_y;
  logic [NUM_REQ-1:0][COLOUR_W-1:0] px_c;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign px_x[g] = req_x[g*X_W +: X_W];
      assign px_y[g] = req_y[g*Y_W +: Y_W];
      assign px_c[g] = req_colour[g*COLOUR_W +: COLOUR_W];
    end
  endgenerate

  // While granted, ptr always names the granted requester, so the data mux
  // can use it directly instead of encoding the one-hot grant.
  logic [X_W-1:0]      sel_x;
  logic [Y_W-1:0]      sel_y;
  logic [COLOUR_W-1:0] sel_c;
  logic                sel_req, sel_last;

  assign sel_x    = px_x[ptr];
  assign sel_y    = px_y[ptr];
  assign sel_c    = px_c[ptr];
  assign sel_req  = req[ptr];
  assign sel_last = req_last[ptr];

  assign ack  = grant & req & {NUM_REQ{enable}};
  assign busy = (state == S_GRANT);

  logic accept;
  assign accept = |ack;

  // Round-robin pick: first requester after ptr, wrapping around.
  logic [PTR_W-1:0] nxt;
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    nxt   = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        nxt   = PTR_W'(idx);
      end
    end
  end

  // All end conditions collapse into one strobe, so coincident ends give a
  // single transition to S_IDLE.
  logic burst_done;
  assign burst_done = (accept && (sel_last || burst_cnt == CNT_W'(MAX_BURST - 1)))
                    || (enable && !sel_req);

  logic plot_ok;
`ifdef ARB_CLIP_EN
  localparam logic [X_W:0] SCR_W = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SCR_H = SCREEN_H[Y_W:0];
  logic clipped;
  assign clipped = ({1'b0, sel_x} >= SCR_W) || ({1'b0, sel_y} >= SCR_H);
  assign plot_ok = !clipped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      clip_cnt <= '0;
    else if (accept && clipped && clip_cnt != 16'hFFFF)
      clip_cnt <= clip_cnt + 16'd1;
  end
`else
  assign plot_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      ptr        <= PTR_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      // Clipped pixels leave the last plotted coordinates on the bus.
      if (accept && plot_ok) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_c;
        vga_plot   <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (enable && |req) begin
            grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << nxt;
            ptr       <= nxt;
            burst_cnt <= '0;
            state     <= S_GRANT;
          end else begin
            grant <= '0;
          end
        end
        S_GRANT: begin
          if (burst_done) begin
            grant <= '0;
            state <= S_IDLE;
          end else if (accept) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_write_arbiter.sv
module tb_vga_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req, req_last;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  grant, ack;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;
`ifdef ARB_CLIP_EN
  logic [15:0] clip_cnt;
`endif

  int checks = 0;
  int errors = 0;

  vga_write_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req(req), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .ack(ack),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy)
`ifdef ARB_CLIP_EN
    , .clip_cnt(clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int x, input int y, input int c);
    req_x[i*8 +: 8]      = 8'(x);
    req_y[i*7 +: 7]      = 7'(y);
    req_colour[i*3 +: 3] = 3'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; req = '0; req_last = '0;
    req_x = '0; req_y = '0; req_colour = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Requester 0 streams pixels 0..n-1 (x=y=p) with req_last on the final one.
  // enable drops for pause_len cycles the first time pixel pause_at is presented.
  int bursts[8];
  task automatic run_stream(input int n, input int pause_at, input int pause_len,
                            output int plots, output int nb, output int gaps);
    int p, cur, paused;
    bit started, en;
    p = 0; plots = 0; cur = 0; nb = 0; gaps = 0; paused = 0; started = 0;
    for (int cyc = 0; cyc < 300 && plots < n; cyc++) begin
      if (vga_plot) begin
        chk("stream_x", 32'(vga_x), 32'(plots));
        chk("stream_y", 32'(vga_y), 32'(plots));
        plots++;
      end
      if (grant == 4'b0000) begin
        if (cur > 0) begin
          if (nb < 8) bursts[nb] = cur;
          nb++;
          cur = 0;
        end
        if (started && p < n) gaps++;
      end
      en = !(p == pause_at && paused < pause_len);
      if (!en) begin
        if (paused >= 1) chk("pause_plot", 32'(vga_plot), 32'd0);
        paused++;
      end
      enable      = en;
      req[0]      = (p < n);
      req_last[0] = (p == n - 1);
      set_px(0, p, p, p % 8);
      #1;
      if (!en) begin
        chk("pause_ack", 32'(ack), 32'd0);
        chk("pause_grant", 32'(grant), 32'd1);
      end
      if (ack[0]) begin
        cur++; p++; started = 1;
      end
      @(posedge clk); #1;
    end
    req = '0;
    enable = 1'b1;
  endtask

  initial begin
    int plots, nb, gaps;

    // T1: reset values, then single-pixel object from requester 0
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_plot", 32'(vga_plot), 32'd0);
    chk("rst_x", 32'(vga_x), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    enable = 1'b1; req = 4'b0001; req_last = 4'b0001; set_px(0, 5, 7, 3);
    #1;
    chk("t1_c0_grant", 32'(grant), 32'd0);
    chk("t1_c0_ack", 32'(ack), 32'd0);
    tick();
    chk("t1_c1_grant", 32'(grant), 32'b0001);
    chk("t1_c1_ack", 32'(ack), 32'b0001);
    chk("t1_c1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c2_plot", 32'(vga_plot), 32'd1);
    chk("t1_c2_x", 32'(vga_x), 32'd5);
    chk("t1_c2_y", 32'(vga_y), 32'd7);
    chk("t1_c2_col", 32'(vga_colour), 32'd3);
    chk("t1_c2_grant", 32'(grant), 32'd0);
    req = '0;
    tick();
    chk("t1_c3_plot", 32'(vga_plot), 32'd0);
    chk("t1_c3_hold_x", 32'(vga_x), 32'd5);

    // T2: all four requesting, one pixel each, grants rotate with idle gaps
    do_reset();
    enable = 1'b1; req = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < 4; i++) set_px(i, 10 + i, i, i);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_grant", 32'(grant), 32'(1 << (k % 4)));
      tick();
      chk("t2_idle", 32'(grant), 32'd0);
      chk("t2_plot", 32'(vga_plot), 32'd1);
      chk("t2_x", 32'(vga_x), 32'(10 + k % 4));
    end
    req = '0;

    // T3: 40-pixel object, bursts capped at 16
    do_reset();
    enable = 1'b1;
    run_stream(40, -1, 0, plots, nb, gaps);
    chk("t3_plots", 32'(plots), 32'd40);
    chk("t3_nbursts", 32'(nb), 32'd3);
    chk("t3_b0", 32'(bursts[0]), 32'd16);
    chk("t3_b1", 32'(bursts[1]), 32'd16);
    chk("t3_b2", 32'(bursts[2]), 32'd8);
    chk("t3_gaps", 32'(gaps), 32'd2);

    // T4: enable low for 5 cycles while pixel 3 is presented
    do_reset();
    enable = 1'b1;
    run_stream(10, 3, 5, plots, nb, gaps);
    chk("t4_plots", 32'(plots), 32'd10);
    chk("t4_nbursts", 32'(nb), 32'd1);
    chk("t4_b0", 32'(bursts[0]), 32'd10);

    // T5: asynchronous reset mid-burst, then requester 0 wins
    do_reset();
    enable = 1'b1; req = 4'b0100; req_last = 4'b0000; set_px(2, 9, 9, 1);
    tick();
    chk("t5_grant", 32'(grant), 32'b0100);
    tick();
    chk("t5_plot", 32'(vga_plot), 32'd1);
    chk("t5_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_async_grant", 32'(grant), 32'd0);
    chk("t5_async_plot", 32'(vga_plot), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    req = 4'b1111; req_last = 4'b1111;
    tick();
    chk("t5_prio", 32'(grant), 32'b0001);
    req = '0;
    tick();

`ifdef ARB_CLIP_EN
    // T6: screen-edge clipping
    do_reset();
    chk("t6_clip_rst", 32'(clip_cnt), 32'd0);
    enable = 1'b1; req = 4'b0001; req_last = 4'b0000; set_px(0, 159, 119, 2);
    tick();
    chk("t6_ack0", 32'(ack), 32'b0001);
    tick();
    chk("t6_plot0", 32'(vga_plot), 32'd1);
    chk("t6_x0", 32'(vga_x), 32'd159);
    set_px(0, 160, 5, 2);
    #1;
    chk("t6_ack1", 32'(ack), 32'b0001);
    tick();
    chk("t6_plot1", 32'(vga_plot), 32'd0);
    set_px(0, 3, 120, 2); req_last = 4'b0001;
    #1;
    chk("t6_ack2", 32'(ack), 32'b0001);
    tick();
    chk("t6_plot2", 32'(vga_plot), 32'd0);
    chk("t6_clip", 32'(clip_cnt), 32'd2);
    chk("t6_grant", 32'(grant), 32'd0);
    req = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
